// File: rtl/cpu_ctrl_fsm_pkg.sv
// cpu_ctrl_pkg: opcode, step and ALU encodings shared by the processor control unit.
// Revision: 1.0
`default_nettype none

package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVNZ = 3'b101;
    localparam logic [2:0] OP_OUT  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

endpackage

`default_nettype wire

// File: rtl/cpu_ctrl_fsm_onehot_dec.sv
// onehot_dec: register index to one-hot vector, gated by an enable.
// Revision: 1.0
`default_nettype none

module onehot_dec #(
    parameter int RW = 3
) (
    input  logic [RW-1:0]    idx,
    input  logic             en,
    output logic [2**RW-1:0] onehot
);

    for (genvar i = 0; i < 2**RW; i++) begin : g_bit
        assign onehot[i] = en && (idx == RW'(i));
    end

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control unit sequencing register file, A/G and ALU over T0-T3.
// Revision: 1.0
`default_nettype none

module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int RW   = 3,
    parameter int DW   = 16,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              run,
    input  logic [DW-1:0]     din,
    input  logic              g_nz,
    output logic              ir_in,
    output logic [2**RW-1:0]  rin,
    output logic [2**RW-1:0]  rout,
    output logic              din_out,
    output logic              g_out,
    output logic              ain,
    output logic              gin,
    output logic [1:0]        alu_op,
    output logic              ext_en,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [CNTW-1:0]   instr_cnt
);

    localparam int NREG = 2**RW;
    localparam int IRW  = 3 + 2*RW;

    step_t            step;
    step_t            step_nxt;
    logic [IRW-1:0]   ir;
    logic [2:0]       op;
    logic [RW-1:0]    x;
    logic [RW-1:0]    y;
    logic [NREG-1:0]  x_oh;
    logic [NREG-1:0]  y_oh;
    logic             rin_x;
    logic             rout_x;
    logic             rout_y;

    assign op = ir[IRW-1 -: 3];
    assign x  = ir[2*RW-1 -: RW];
    assign y  = ir[RW-1:0];

    onehot_dec #(.RW(RW)) u_dec_x (.idx(x), .en(1'b1), .onehot(x_oh));
    onehot_dec #(.RW(RW)) u_dec_y (.idx(y), .en(1'b1), .onehot(y_oh));

    // Only the low IRW bits of din form an instruction; the rest is immediate data.
    if (DW > IRW) begin : g_din_upper
        logic unused_din_upper;
        assign unused_din_upper = ^din[DW-1:IRW];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            step      <= T0;
            ir        <= '0;
            instr_cnt <= '0;
        end else begin
            step <= step_nxt;
            if (ir_in)
                ir <= din[IRW-1:0];
            if (done)
                instr_cnt <= instr_cnt + 1'b1;
        end
    end

    always_comb begin
        step_nxt = step;
        ir_in    = 1'b0;
        rin_x    = 1'b0;
        rout_x   = 1'b0;
        rout_y   = 1'b0;
        din_out  = 1'b0;
        g_out    = 1'b0;
        ain      = 1'b0;
        gin      = 1'b0;
        alu_op   = 2'b00;
        ext_en   = 1'b0;
        done     = 1'b0;
        err      = 1'b0;

        case (step)
            T0: begin
                ir_in = run;
                if (run)
                    step_nxt = T1;
            end
            T1: begin
                step_nxt = T0;
                case (op)
                    OP_MV: begin
                        rout_y = 1'b1;
                        rin_x  = 1'b1;
                        done   = 1'b1;
                    end
                    OP_MVI: begin
                        din_out = 1'b1;
                        rin_x   = 1'b1;
                        done    = 1'b1;
                    end
                    OP_MVNZ: begin
                        rout_y = g_nz;
                        rin_x  = g_nz;
                        done   = 1'b1;
                    end
                    OP_OUT: begin
                        rout_x = 1'b1;
                        ext_en = 1'b1;
                        done   = 1'b1;
                    end
                    OP_ILL: begin
                        done = 1'b1;
                        err  = 1'b1;
                    end
                    default: begin
                        rout_x   = 1'b1;
                        ain      = 1'b1;
                        step_nxt = T2;
                    end
                endcase
            end
            T2: begin
                rout_y   = 1'b1;
                gin      = 1'b1;
                alu_op   = (op == OP_SUB) ? ALU_SUB :
                           (op == OP_AND) ? ALU_AND : ALU_ADD;
                step_nxt = T3;
            end
            default: begin
                g_out    = 1'b1;
                rin_x    = 1'b1;
                done     = 1'b1;
                step_nxt = T0;
            end
        endcase

        rin  = rin_x  ? x_oh : '0;
        rout = rout_x ? x_oh : (rout_y ? y_oh : '0);
        busy = (step != T0);
    end

endmodule

`default_nettype wire

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Parametrised multi-cycle control unit for the simple bus-based processor. It latches the instruction word from din, sequences the register file, A/G registers and ALU over steps T0-T3, and reports completion with a done pulse. Compared with the previous control unit, it adds generic register count and data width, AND, conditional move (mvnz), illegal-opcode detection, a busy flag and a retired-instruction counter.

Parameters:
RW, 3, register index width; NREG = 2**RW registers
DW, 16, data bus width; must satisfy DW >= IRW
IRW (localparam), 3+2*RW, instruction width: {op[2:0], x[RW-1:0], y[RW-1:0]}
CNTW, 16, retired-instruction counter width

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
run  in  1  start request, sampled only in T0
din  in  DW  instruction/immediate bus; IR captures din[IRW-1:0]
g_nz  in  1  G register non-zero flag from datapath
ir_in  out  1  IR load strobe
rin  out  NREG  one-hot register write enable
rout  out  NREG  one-hot register-to-bus select
din_out  out  1  din-to-bus select
g_out  out  1  G-to-bus select
ain  out  1  A register load
gin  out  1  G register load
alu_op  out  2  00 add, 01 sub, 10 and, 11 reserved
ext_en  out  1  external output strobe
done  out  1  instruction complete (one cycle)
err  out  1  illegal opcode, asserted together with done
busy  out  1  state != T0
instr_cnt  out  CNTW  retired-instruction count

Behaviour:
- Registered state: step (T0..T3), IR, instr_cnt. All other outputs are combinational from step, IR, run and g_nz.
- Reset (rstn=0 at a clk edge, including mid-instruction): step<=T0, IR<=0, instr_cnt<=0. After reset, with run=0, every output is 0.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 mvnz, 110 out, 111 illegal.
- T0: ir_in=run. If run=1: IR<=din[IRW-1:0] and step<=T1. Otherwise hold in T0.
- T1 actions by opcode:
  - mv: rout[y], rin[x], done; go to T0.
  - mvi: din_out, rin[x], done (immediate taken from din this cycle); go to T0.
  - mvnz: if g_nz, rout[y] and rin[x]; done is asserted regardless; go to T0.
  - out: rout[x], ext_en, done; go to T0.
  - illegal: done and err only; go to T0.
  - add/sub/and: rout[x], ain; go to T2.
- T2: rout[y], gin, alu_op per opcode (add 00, sub 01, and 10); go to T3.
- T3: g_out, rin[x], done; go to T0.
- Cycle counts: mv/mvi/mvnz/out/illegal take 2 cycles including the fetch; ALU operations take 4.
- done is high for exactly one cycle per instruction. instr_cnt increments on every cycle with done=1 (illegal included) and wraps modulo 2**CNTW.
- run is ignored outside T0; dropping run mid-instruction does not stall. If run is high in the cycle after done, the next instruction fetches immediately, giving back-to-back execution.
- Bus exclusivity: at most one of rout bits, din_out, g_out is high in any cycle. At most one rin bit is high.
- x==y is legal; for example, add r1,r1 doubles r1.

Decomposition:
- Package cpu_ctrl_pkg holds the opcode localparams (OP_MV..OP_ILL), step encodings T0..T3, and ALU_ADD/SUB/AND codes.
- One sub-module, onehot_dec #(RW), converts an index to a 2**RW one-hot vector with an enable. It is instantiated twice: once for x, once for y.

Test Plan:
- Reset, then run=1 with din=9'h015 (mv r2,r5) -> T0: ir_in=1. T1: rout=8'h20, rin=8'h04, done=1. instr_cnt becomes 1.
- din=9'h08B (add r1,r3), run held high -> T1: rout=8'h02, ain=1. T2: rout=8'h08, gin=1, alu_op=00. T3: g_out=1, rin=8'h02, done=1. 4 cycles total.
- din=9'h160 (mvnz r4,r0) with g_nz=0 -> T1: rin=0, rout=0, done=1. Repeat with g_nz=1 -> rout=8'h01, rin=8'h10.
- din=9'h1C0 (illegal) -> T1: done=1, err=1, all enables 0. Next cycle returns to T0. instr_cnt increments.
- Reset mid-op: rstn=0 in T2 of a sub (9'h0D1) -> next cycle step=T0, busy=0, gin=0, instr_cnt=0. With run=0, no fetch occurs.
- Back-to-back mvi (9'h048), immediate 16'h00AB, then mv with run held high -> done pulses in cycles 2 and 4. instr_cnt=2. Exclusivity assertion holds in every cycle.
